c_recv: RTL and testbench
=========================

// Module: c_recv
// PURPOSE
//   Clocked receiver for the self-timed C-element pipeline's 4-phase Send/Ack handshake.
//   Sits at the output end of a C-element stage chain.
//   Synchronises Send_in into the CP domain, captures bundled Data_in and buffers it in a FIFO.
//   Returns Ack_out to the last self-timed stage and presents data on a valid/ready port.
// PARAMETERS
//   DW          8   data width (bundled with Send_in)
//   DEPTH       4   FIFO entries; power of two, >= 2
//   SYNC_STAGES 2   flops in Send_in synchroniser; >= 2
// PORTS
//   CP          in   1                   clock, rising edge
//   MR_n        in   1                   master reset, asynchronous, active-low
//   Send_in     in   1                   request from upstream C stage (4-phase)
//   Data_in     in   DW                  bundled data; stable from Send_in rise until Ack_out rise
//   Ack_out     out  1                   acknowledge to upstream C stage
//   Dout        out  DW                  FIFO head (show-ahead)
//   Dout_valid  out  1                   Dout holds a valid entry
//   Dout_ready  in   1                   consumer accepts Dout when Dout_valid=1
//   Count       out  $clog2(DEPTH+1)     FIFO occupancy
//   Full        out  1                   Count == DEPTH
// BEHAVIOUR
//   Reset (MR_n=0, async): state=IDLE, sync flops=0, Ack_out=0, Count=0, Dout_valid=0, Full=0, Dout=0.
//   Send_s is the last synchroniser flop; all decisions use Send_s only, never raw Send_in.
//   FSM (registered Ack_out):
//     IDLE:     Ack_out=0.
//               If Send_s=1 and Full=0: write Data_in to FIFO, Ack_out<=1, go to WAIT_LOW.
//               If Send_s=1 and Full=1: hold state; Ack_out stays 0 (backpressure).
//     WAIT_LOW: Ack_out=1; no further write.
//               When Send_s=0: Ack_out<=0, go to IDLE.
//   Exactly one FIFO write per Send_in high phase; a Send_in held high never causes a double write.
//   Latency:
//     - Ack_out rises on the (SYNC_STAGES+1)th CP edge after Send_in rise (3 with defaults), FIFO not full.
//     - Ack_out falls on the (SYNC_STAGES+1)th edge after Send_in fall.
//   Write-to-read: Dout_valid=1 and Dout=entry from the edge after the write edge.
//   Pop: Dout_valid & Dout_ready at an edge removes the head; next entry shows after that edge.
//   Simultaneous write and pop: Count unchanged, order preserved.
//   Full is evaluated on pre-pop Count, so a pop in the same cycle does not enable a write.
//   The write occurs on the following cycle.
//   Empty: Dout_valid=0, Dout holds last value, Dout_ready ignored.
//   Pointers wrap modulo DEPTH; Count saturates by construction (never write when Full, never pop when empty).
//   Reset mid-handshake: Ack_out drops immediately and FIFO contents are discarded.
//     - Upstream C stages share the same master reset and must be reset together.
//     - A Send_in still high after reset release is taken as a new token.
//   Data integrity: Data_in is sampled on the write edge only.
//     - Upstream bundling delay guarantees stability until Ack_out rises.
// CONFIGURATION
//   C_RECV_PARITY_EN defined:
//     - adds input Par_in (1) and output Par_err (1).
//     - On each write, Par_err<=1 if ^{Data_in,Par_in} != 0 (even parity).
//     - Par_err is sticky; it is cleared only by MR_n=0 (reset value 0).
//     - The data is still written.
//   C_RECV_PARITY_EN undefined: no Par_in/Par_err ports, no parity logic.
// TESTING
//   1. MR_n=0 with Send_in=1 -> Ack_out=0, Dout_valid=0, Count=0, Full=0.
//      Release MR_n -> one token captured, Ack_out=1 by edge 3.
//   2. Data_in=8'hA5, raise Send_in -> Ack_out=1 on 3rd edge, Dout_valid=1 with Dout=8'hA5 next edge.
//      Drop Send_in -> Ack_out=0 on 3rd edge; Count=1.
//   3. Dout_ready=0, send 8'h01..8'h04 -> Full=1, Count=4.
//      5th token 8'h05 -> Ack_out stays 0.
//      Pulse Dout_ready -> 8'h05 acked after one more edge.
//      Drain order 02,03,04,05.
//   4. Count=2, write edge coincides with Dout_valid&Dout_ready -> Count stays 2, FIFO order intact.
//   5. MR_n pulsed low while Ack_out=1 and Count=3 -> Ack_out=0 asynchronously, Count=0, Dout_valid=0.
//   6. (C_RECV_PARITY_EN) Data_in=8'h03, Par_in=1 -> Par_err=1 after write edge.
//      Par_err stays 1 across later good tokens; entry 8'h03 still delivered.

Source files
------------

// File: rtl/c_recv.sv
// Clocked receiver for a 4-phase Send/Ack self-timed pipeline: synchronises Send_in, captures Data_in into a show-ahead FIFO.
// Optional even-parity check on captured tokens is enabled by defining C_RECV_PARITY_EN.
module c_recv #(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         CP,
  input  logic                         MR_n,
  input  logic                         Send_in,
  input  logic [DW-1:0]                Data_in,
`ifdef C_RECV_PARITY_EN
  input  logic                         Par_in,
  output logic                         Par_err,
`endif
  output logic                         Ack_out,
  output logic [DW-1:0]                Dout,
  output logic                         Dout_valid,
  input  logic                         Dout_ready,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   send_s;
  logic                   wr_en;
  logic                   pop;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          rd_sel;
  logic [CW-1:0]          count_next;
  logic [CW-1:0]          after_pop;
  logic [DW-1:0]          mem [DEPTH];

  assign send_s     = sync_q[SYNC_STAGES-1];
  // Full is the registered pre-pop flag, so a same-cycle pop never opens a write slot.
  assign wr_en      = (state == IDLE) && send_s && !Full;
  assign pop        = Dout_valid && Dout_ready;
  assign count_next = Count + CW'(wr_en) - CW'(pop);
  assign after_pop  = Count - CW'(pop);
  assign rd_sel     = rd_ptr + AW'(pop);

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Send_in};
    end
  end

  // Handshake FSM: one write per Send high phase, Ack held until Send drops.
  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      state   <= IDLE;
      Ack_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            state   <= WAIT_LOW;
            Ack_out <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!send_s) begin
            state   <= IDLE;
            Ack_out <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          Ack_out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (wr_en) begin
      mem[wr_ptr] <= Data_in;
    end
  end

  // Output stage sees only entries written before this edge, giving one cycle write-to-read.
  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Count      <= '0;
      Full       <= 1'b0;
      Dout       <= '0;
      Dout_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_sel;
      Count      <= count_next;
      Full       <= (count_next == CW'(DEPTH));
      Dout_valid <= (after_pop != '0);
      if (after_pop != '0) begin
        Dout <= mem[rd_sel];
      end
    end
  end

`ifdef C_RECV_PARITY_EN
  // Sticky even-parity error; the token is still stored.
  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      Par_err <= 1'b0;
    end else if (wr_en && (^{Data_in, Par_in})) begin
      Par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_c_recv.sv
// Directed bench for c_recv with a data scoreboard; parity steps run when C_RECV_PARITY_EN is defined.
module tb_c_recv;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          CP = 1'b0;
  logic          MR_n;
  logic          Send_in;
  logic [DW-1:0] Data_in;
  logic          Ack_out;
  logic [DW-1:0] Dout;
  logic          Dout_valid;
  logic          Dout_ready;
  logic [CW-1:0] Count;
  logic          Full;
`ifdef C_RECV_PARITY_EN
  logic          Par_in;
  logic          Par_err;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [$];
  logic          par_flip = 1'b0;

  c_recv #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .CP         (CP),
    .MR_n       (MR_n),
    .Send_in    (Send_in),
    .Data_in    (Data_in),
`ifdef C_RECV_PARITY_EN
    .Par_in     (Par_in),
    .Par_err    (Par_err),
`endif
    .Ack_out    (Ack_out),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Dout_ready (Dout_ready),
    .Count      (Count),
    .Full       (Full)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (Ack_out !== lvl && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(Ack_out), 32'(lvl));
  endtask

  task automatic drive_data(input logic [DW-1:0] d);
    Data_in = d;
`ifdef C_RECV_PARITY_EN
    Par_in = (^d) ^ par_flip;
`endif
  endtask

  // Full handshake for one token; the expected entry is queued when it is driven.
  task automatic send_token(input logic [DW-1:0] d);
    drive_data(d);
    sb.push_back(d);
    Send_in = 1'b1;
    wait_ack(1'b1, "ack_rise");
    Send_in = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  // Accept one entry from the output port and compare it with the scoreboard head.
  task automatic pop_one(input string tag);
    logic [DW-1:0] exp;
    int n = 0;
    while (Dout_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(Dout_valid), 32'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'(1));
    end else begin
      exp = sb.pop_front();
      chk(tag, 32'(Dout), 32'(exp));
    end
    Dout_ready = 1'b1;
    tick();
    Dout_ready = 1'b0;
  endtask

  initial begin
    MR_n       = 1'b0;
    Send_in    = 1'b1;
    Dout_ready = 1'b0;
    drive_data(8'h5A);
    #2;
    chk("rst_ack",   32'(Ack_out),    32'(0));
    chk("rst_valid", 32'(Dout_valid), 32'(0));
    chk("rst_count", 32'(Count),      32'(0));
    chk("rst_full",  32'(Full),       32'(0));
    chk("rst_dout",  32'(Dout),       32'(0));
    repeat (2) tick();
    chk("rst_hold_ack", 32'(Ack_out), 32'(0));

    // Send_in held through reset is taken as a token once reset releases.
    MR_n = 1'b1;
    sb.push_back(8'h5A);
    tick(); chk("t1_ack_e1", 32'(Ack_out), 32'(0));
    tick(); chk("t1_ack_e2", 32'(Ack_out), 32'(0));
    tick(); chk("t1_ack_e3", 32'(Ack_out), 32'(1));
    pop_one("t1_data");
    Send_in = 1'b0;
    wait_ack(1'b0, "t1_ack_fall");
    chk("t1_count", 32'(Count), 32'(0));

    // Latency and single write while Send_in stays high.
    drive_data(8'hA5);
    sb.push_back(8'hA5);
    Send_in = 1'b1;
    tick(); chk("t2_ack_e1", 32'(Ack_out), 32'(0));
    tick(); chk("t2_ack_e2", 32'(Ack_out), 32'(0));
    tick(); chk("t2_ack_e3", 32'(Ack_out), 32'(1));
    chk("t2_valid_wr_edge", 32'(Dout_valid), 32'(0));
    chk("t2_count_wr", 32'(Count), 32'(1));
    tick();
    chk("t2_valid_next", 32'(Dout_valid), 32'(1));
    chk("t2_dout_next",  32'(Dout),       32'(8'hA5));
    repeat (4) tick();
    chk("t2_no_double", 32'(Count), 32'(1));
    Send_in = 1'b0;
    tick(); chk("t2_fall_e1", 32'(Ack_out), 32'(1));
    tick(); chk("t2_fall_e2", 32'(Ack_out), 32'(1));
    tick(); chk("t2_fall_e3", 32'(Ack_out), 32'(0));
    chk("t2_count", 32'(Count), 32'(1));
    pop_one("t2_data");
    chk("t2_empty_valid", 32'(Dout_valid), 32'(0));
    chk("t2_empty_hold",  32'(Dout),       32'(8'hA5));
    chk("t2_empty_count", 32'(Count),      32'(0));

    // Fill to full, then backpressure on the fifth token.
    for (int i = 1; i <= 4; i++) send_token(DW'(i));
    chk("t3_full",  32'(Full),  32'(1));
    chk("t3_count", 32'(Count), 32'(4));
    drive_data(8'h05);
    sb.push_back(8'h05);
    Send_in = 1'b1;
    repeat (6) tick();
    chk("t3_bp_ack",   32'(Ack_out), 32'(0));
    chk("t3_bp_count", 32'(Count),   32'(4));
    pop_one("t3_d01");
    chk("t3_ack_after_pop", 32'(Ack_out), 32'(0));
    tick();
    chk("t3_ack_late", 32'(Ack_out), 32'(1));
    chk("t3_count_refill", 32'(Count), 32'(4));
    Send_in = 1'b0;
    wait_ack(1'b0, "t3_ack_fall");
    for (int i = 0; i < 4; i++) pop_one("t3_drain");
    chk("t3_drained", 32'(Count), 32'(0));

    // Write and pop on the same edge.
    send_token(8'h11);
    send_token(8'h22);
    chk("t4_count_pre", 32'(Count), 32'(2));
    drive_data(8'h33);
    sb.push_back(8'h33);
    Send_in = 1'b1;
    tick();
    tick();
    chk("t4_head", 32'(Dout), 32'(sb.pop_front()));
    Dout_ready = 1'b1;
    tick();
    Dout_ready = 1'b0;
    chk("t4_ack",   32'(Ack_out), 32'(1));
    chk("t4_count", 32'(Count),   32'(2));
    Send_in = 1'b0;
    wait_ack(1'b0, "t4_ack_fall");
    pop_one("t4_d22");
    pop_one("t4_d33");

    // Asynchronous reset mid-handshake.
    send_token(8'h44);
    send_token(8'h55);
    drive_data(8'h66);
    Send_in = 1'b1;
    wait_ack(1'b1, "t5_ack_up");
    chk("t5_count_pre", 32'(Count), 32'(3));
    #2;
    MR_n    = 1'b0;
    Send_in = 1'b0;
    #1;
    chk("t5_ack",   32'(Ack_out),    32'(0));
    chk("t5_count", 32'(Count),      32'(0));
    chk("t5_valid", 32'(Dout_valid), 32'(0));
    chk("t5_full",  32'(Full),       32'(0));
    sb.delete();
    tick();
    MR_n = 1'b1;
    tick();
    send_token(8'h77);
    pop_one("t5_post");

`ifdef C_RECV_PARITY_EN
    chk("t6_perr_init", 32'(Par_err), 32'(0));
    par_flip = 1'b1;
    send_token(8'h03);
    chk("t6_perr_set", 32'(Par_err), 32'(1));
    par_flip = 1'b0;
    send_token(8'h81);
    chk("t6_perr_sticky", 32'(Par_err), 32'(1));
    pop_one("t6_d03");
    pop_one("t6_d81");
`endif

    chk("end_sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
